mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Two-master arbiter that shares the single unified memory port (address/ren/wen/wmask/wdata → rdata/valid handshake) between the core's memory FSM (master 0) and a second bus master such as the program loader or a DMA engine (master 1). It runs one transaction at a time, registers the memory-side request, and uses round-robin priority so neither master starves. A watchdog counter ends a transaction that never gets a memory acknowledge. It sits between the masters and the memory model/controller.

## Interface
- TIMEOUT, 255: max cycles in BUSY waiting for valid_mem before the transaction is aborted; must be ≥1.
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- m0_address, m1_address  in  64  master byte address
- m0_ren, m1_ren  in  1  read request
- m0_wen, m1_wen  in  1  write request
- m0_wdata, m1_wdata  in  64  write data
- m0_wmask, m1_wmask  in  8  byte write mask
- m0_rdata, m1_rdata  out  64  read data; valid only with the matching mX_valid
- m0_valid, m1_valid  out  1  completion strobe, one cycle
- m0_err, m1_err  out  1  high with mX_valid when the transaction timed out
- address_mem  out  64  memory address (registered)
- ren_mem, wen_mem  out  1  memory read/write request (registered)
- wmask_mem  out  8  memory byte mask (registered)
- wdata_mem  out  64  memory write data (registered)
- rdata_mem  in  64  memory read data
- valid_mem  in  1  memory acknowledge
- busy  out  1  high in BUSY
- timeout_err  out  1  sticky flag, set on any timeout, cleared only by reset

## Operation
- A master requests when mX_ren | mX_wen. The request must stay stable until mX_valid. If ren and wen are both high, it is a write.
- States are IDLE and BUSY.
- **IDLE**
  - If no master requests, stay in IDLE and hold the mem outputs at 0.
  - If one master requests, grant it.
  - If both request, grant the master that is not last_grant.
  - On grant: latch the master's address, ren, wen, wmask and wdata into the mem registers. Update last_grant, set cnt=0 and go to BUSY.
- **BUSY**
  - Hold the mem registers and ignore all master inputs.
  - If valid_mem:
    - Drive mX_valid=1 and mX_rdata=rdata_mem for the granted master, combinationally in the same cycle.
    - Zero all mem registers and return to IDLE.
  - Else if cnt==TIMEOUT-1:
    - Drive mX_valid=1 and mX_err=1, with mX_rdata=0.
    - Set timeout_err, zero the mem registers and return to IDLE.
  - Else cnt++.
- mX_valid and mX_err for the non-granted master are always 0. The non-granted mX_rdata is 0.
- valid_mem in IDLE is a late or stray acknowledge: ignore it, drive no strobe, and leave the flag unchanged.
- Reset values: all mem outputs 0, all mX_valid/mX_err 0, busy=0, timeout_err=0, state=IDLE, cnt=0, last_grant=1 (so master 0 wins the first tie).
- Reset asserted mid-transaction returns to IDLE immediately. No completion strobe is issued and the mem request drops asynchronously.
- cnt width is $clog2(TIMEOUT+1). cnt never wraps because the timeout check comes first.

## Timing
- Request sampled in IDLE at edge t → mem outputs valid after edge t, busy=1.
- Earliest acknowledge is valid_mem in the cycle after edge t, which drives mX_valid in that same cycle. Minimum request-to-valid latency is 1 cycle.
- The completing edge returns to IDLE. The next arbitration happens at the following edge, so back-to-back transactions cost 2 cycles each minimum.
- A master that still holds a request in the IDLE cycle after its own valid is treated as a new request. Masters must update or drop the request on the valid cycle.
- With both masters requesting continuously, grants alternate 0,1,0,1…
- Timeout: the abort strobe comes TIMEOUT cycles after entering BUSY.

## Structure
- Shared package mem_arb_pkg:
  - state enum with IDLE=1'b0, BUSY=1'b1
  - master ID constants M0=1'b0, M1=1'b1
  - default TIMEOUT value
- Sub-module rr_pick2: purely combinational. Takes req[1:0] and last_grant, outputs grant_id and grant_valid. Used by the IDLE decision; last_grant is stored in the parent.

## Test plan
- Reset → all outputs 0. Then m0 read at 0x80 with mem acking 2 cycles later, rdata_mem=0xDEADBEEF_00000013 → m0_valid one cycle with that data; m1 outputs stay 0.
- m0 and m1 both request from reset and hold, mem acks every transaction after 1 cycle → grant order m0,m1,m0,m1. The address_mem sequence matches.
- m1 write addr 0x1000, wdata 0x1122334455667788, wmask 0xF0 → mem outputs carry exactly those values while BUSY, then return to 0 after the ack.
- TIMEOUT=4, m0 read, valid_mem never asserted → m0_valid=m0_err=1 exactly 4 cycles after BUSY entry, timeout_err sticky. A later valid_mem in IDLE produces no strobe.
- rstn pulsed low while BUSY → mem outputs drop to 0 asynchronously. After release, a tie grants m0 first.
- m0 changes address while BUSY → address_mem keeps the latched value until the ack.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory port arbiter.
// Holds the FSM state encoding, master IDs and the memory request bundle.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int DEFAULT_TIMEOUT = 255;

    typedef struct packed {
        logic [63:0] address;
        logic        ren;
        logic        wen;
        logic [7:0]  wmask;
        logic [63:0] wdata;
    } mem_req_t;

    // A request carrying both ren and wen is a write, so ren is masked off.
    function automatic mem_req_t make_req(
        input logic [63:0] address,
        input logic        ren,
        input logic        wen,
        input logic [7:0]  wmask,
        input logic [63:0] wdata
    );
        mem_req_t r;
        r.address = address;
        r.ren     = ren & ~wen;
        r.wen     = wen;
        r.wmask   = wmask;
        r.wdata   = wdata;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the master that did not win last time
// is chosen. Purely combinational; the caller owns the last_grant register.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_id,
    output logic       grant_valid
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        grant_id    = M0;
        grant_valid = |req;
        unique case (req)
            2'b01:   grant_id = M0;
            2'b10:   grant_id = M1;
            2'b11:   grant_id = (last_grant == M0) ? M1 : M0;
            default: grant_id = M0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between two masters, one transaction at a time,
// with round-robin tie breaking and a watchdog that aborts unacknowledged accesses.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic [63:0] m0_address,
    input  logic        m0_ren,
    input  logic        m0_wen,
    input  logic [63:0] m0_wdata,
    input  logic [7:0]  m0_wmask,
    output logic [63:0] m0_rdata,
    output logic        m0_valid,
    output logic        m0_err,

    input  logic [63:0] m1_address,
    input  logic        m1_ren,
    input  logic        m1_wen,
    input  logic [63:0] m1_wdata,
    input  logic [7:0]  m1_wmask,
    output logic [63:0] m1_rdata,
    output logic        m1_valid,
    output logic        m1_err,

    output logic [63:0] address_mem,
    output logic        ren_mem,
    output logic        wen_mem,
    output logic [7:0]  wmask_mem,
    output logic [63:0] wdata_mem,
    input  logic [63:0] rdata_mem,
    input  logic        valid_mem,

    output logic        busy,
    output logic        timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          last_grant, last_grant_nxt;
    logic          timeout_err_nxt;
    mem_req_t      mem_q, mem_d;
    mem_req_t      m0_req, m1_req;

    logic          grant_id, grant_valid;
    logic          done, abort;

    assign m0_req = make_req(m0_address, m0_ren, m0_wen, m0_wmask, m0_wdata);
    assign m1_req = make_req(m1_address, m1_ren, m1_wen, m1_wmask, m1_wdata);

    rr_pick2 u_pick (
        .req         ({m1_ren | m1_wen, m0_ren | m0_wen}),
        .last_grant  (last_grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    // In BUSY the owner of the transaction is always last_grant.
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        last_grant_nxt  = last_grant;
        timeout_err_nxt = timeout_err;
        mem_d           = mem_q;
        done            = 1'b0;
        abort           = 1'b0;
        unique case (state)
            IDLE: begin
                mem_d = '0;
                if (grant_valid) begin
                    mem_d          = (grant_id == M1) ? m1_req : m0_req;
                    last_grant_nxt = grant_id;
                    cnt_nxt        = '0;
                    state_nxt      = BUSY;
                end
            end
            BUSY: begin
                if (valid_mem) begin
                    done      = 1'b1;
                    mem_d     = '0;
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    abort           = 1'b1;
                    timeout_err_nxt = 1'b1;
                    mem_d           = '0;
                    state_nxt       = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            cnt         <= '0;
            last_grant  <= M1;
            timeout_err <= 1'b0;
            mem_q       <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            last_grant  <= last_grant_nxt;
            timeout_err <= timeout_err_nxt;
            mem_q       <= mem_d;
        end
    end

    assign address_mem = mem_q.address;
    assign ren_mem     = mem_q.ren;
    assign wen_mem     = mem_q.wen;
    assign wmask_mem   = mem_q.wmask;
    assign wdata_mem   = mem_q.wdata;
    assign busy        = (state == BUSY);

    assign m0_valid = (done | abort) && (last_grant == M0);
    assign m1_valid = (done | abort) && (last_grant == M1);
    assign m0_err   = abort && (last_grant == M0);
    assign m1_err   = abort && (last_grant == M1);
    assign m0_rdata = (done && (last_grant == M0)) ? rdata_mem : '0;
    assign m1_rdata = (done && (last_grant == M1)) ? rdata_mem : '0;

endmodule
